// File: rtl/hub75_pkg.sv
// hub75_pkg: shared FSM encoding, default geometry and word bit-index helper for the HUB75 line shifter
package hub75_pkg;

    localparam int DEF_N_BANKS     = 2;
    localparam int DEF_N_CHANS     = 3;
    localparam int DEF_N_PLANES    = 8;
    localparam int DEF_N_COLS      = 64;
    localparam int DEF_ADDR_WIDTH  = 6;
    localparam int DEF_PLANE_WIDTH = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Position of one plane bit of one bank/channel inside a line-buffer word
    function automatic int bit_idx(input int bank, input int chan, input int plane,
                                   input int n_chans, input int n_planes);
        return (bank * n_chans + chan) * n_planes + plane;
    endfunction

endpackage

// File: rtl/hub75_line_shifter_if.sv
// hub75_line_shifter_if: control, line-buffer read and panel shift signals; ctrl_rev exists only with HUB75_LINE_SHIFTER_REVERSE_EN
interface hub75_line_shifter_if import hub75_pkg::*; #(
    parameter int N_BANKS     = DEF_N_BANKS,
    parameter int N_CHANS     = DEF_N_CHANS,
    parameter int N_PLANES    = DEF_N_PLANES,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int PLANE_WIDTH = DEF_PLANE_WIDTH
);
    logic                                  ctrl_go;
    logic [PLANE_WIDTH-1:0]                ctrl_plane;
`ifdef HUB75_LINE_SHIFTER_REVERSE_EN
    logic                                  ctrl_rev;
`endif
    logic                                  ctrl_rdy;
    logic                                  ctrl_done;
    logic [ADDR_WIDTH-1:0]                 lb_rd_addr;
    logic                                  lb_rd_ena;
    logic [N_BANKS*N_CHANS*N_PLANES-1:0]   lb_rd_data;
    logic [N_BANKS*N_CHANS-1:0]            phy_data;
    logic                                  phy_clk;

    modport slave (
`ifdef HUB75_LINE_SHIFTER_REVERSE_EN
        input  ctrl_rev,
`endif
        input  ctrl_go, ctrl_plane, lb_rd_data,
        output ctrl_rdy, ctrl_done, lb_rd_addr, lb_rd_ena, phy_data, phy_clk
    );

    modport master (
`ifdef HUB75_LINE_SHIFTER_REVERSE_EN
        output ctrl_rev,
`endif
        output ctrl_go, ctrl_plane, lb_rd_data,
        input  ctrl_rdy, ctrl_done, lb_rd_addr, lb_rd_ena, phy_data, phy_clk
    );

endinterface

// File: rtl/hub75_plane_select.sv
// hub75_plane_select: combinational pick of one bitplane bit for every bank/channel of a line-buffer word
module hub75_plane_select import hub75_pkg::*; #(
    parameter int N_BANKS     = DEF_N_BANKS,
    parameter int N_CHANS     = DEF_N_CHANS,
    parameter int N_PLANES    = DEF_N_PLANES,
    parameter int PLANE_WIDTH = DEF_PLANE_WIDTH
) (
    input  logic [N_BANKS*N_CHANS*N_PLANES-1:0] word,
    input  logic [PLANE_WIDTH-1:0]              plane,
    output logic [N_BANKS*N_CHANS-1:0]          bits
);

    for (genvar b = 0; b < N_BANKS; b++) begin : g_b
        for (genvar c = 0; c < N_CHANS; c++) begin : g_c
            logic [N_PLANES-1:0] chunk;
            assign chunk = word[bit_idx(b, c, 0, N_CHANS, N_PLANES) +: N_PLANES];
            // Out-of-range planes read as zero so the line still shifts with defined levels
            assign bits[b*N_CHANS+c] = (int'(plane) < N_PLANES) ? chunk[plane] : 1'b0;
        end
    end

endmodule

// File: rtl/hub75_line_shifter.sv
// hub75_line_shifter: scans one line-buffer line per go and shifts one bitplane to the panel; HUB75_LINE_SHIFTER_REVERSE_EN adds descending column order
module hub75_line_shifter import hub75_pkg::*; #(
    parameter int N_BANKS     = DEF_N_BANKS,
    parameter int N_CHANS     = DEF_N_CHANS,
    parameter int N_PLANES    = DEF_N_PLANES,
    parameter int N_COLS      = DEF_N_COLS,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int PLANE_WIDTH = DEF_PLANE_WIDTH
) (
    input logic                clk,
    input logic                rst_n,
    hub75_line_shifter_if.slave bus
);

    localparam logic [ADDR_WIDTH:0]   LAST_COL  = (ADDR_WIDTH+1)'(N_COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_COLS - 1);

    logic [1:0]                 state, state_n;
    logic                       phase, phase_n;
    logic [ADDR_WIDTH:0]        col, col_n;
    logic [PLANE_WIDTH-1:0]     plane;
    logic                       accept, rev_n, ena_n;
    logic [ADDR_WIDTH-1:0]      addr_n;
    logic                       rd_vld, ld;
    logic [N_BANKS*N_CHANS-1:0] sel;

    assign accept = (state == S_IDLE) && bus.ctrl_go;

`ifdef HUB75_LINE_SHIFTER_REVERSE_EN
    logic rev;
    assign rev_n = accept ? bus.ctrl_rev : rev;
    // Scan direction is fixed for the whole line once go is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) rev <= 1'b0;
        else        rev <= rev_n;
    end
`else
    assign rev_n = 1'b0;
`endif

    // Next-state logic: two cycles per column, drain waits for the final phy_clk high
    always_comb begin
        state_n = state;
        phase_n = phase;
        col_n   = col;
        if (accept) begin
            state_n = S_SHIFT;
            phase_n = 1'b0;
            col_n   = '0;
        end else if (state == S_SHIFT) begin
            phase_n = ~phase;
            if (phase) begin
                col_n = col + 1'b1;
                if (col == LAST_COL) state_n = S_DRAIN;
            end
        end else if (state == S_DRAIN && bus.phy_clk) begin
            state_n = S_DONE;
        end else if (state == S_DONE) begin
            state_n = S_IDLE;
        end
    end

    assign ena_n  = (state_n == S_SHIFT) && !phase_n;
    assign addr_n = rev_n ? LAST_ADDR - col_n[ADDR_WIDTH-1:0] : col_n[ADDR_WIDTH-1:0];

    // Control registers; outputs are computed from next state so they line up with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            phase          <= 1'b0;
            col            <= '0;
            plane          <= '0;
            bus.ctrl_rdy   <= 1'b1;
            bus.ctrl_done  <= 1'b0;
            bus.lb_rd_ena  <= 1'b0;
            bus.lb_rd_addr <= '0;
        end else begin
            state          <= state_n;
            phase          <= phase_n;
            col            <= col_n;
            if (accept) plane <= bus.ctrl_plane;
            bus.ctrl_rdy   <= (state_n == S_IDLE);
            bus.ctrl_done  <= (state_n == S_DONE);
            bus.lb_rd_ena  <= ena_n;
            if (ena_n) bus.lb_rd_addr <= addr_n;
        end
    end

    hub75_plane_select #(
        .N_BANKS    (N_BANKS),
        .N_CHANS    (N_CHANS),
        .N_PLANES   (N_PLANES),
        .PLANE_WIDTH(PLANE_WIDTH)
    ) u_sel (
        .word (bus.lb_rd_data),
        .plane(plane),
        .bits (sel)
    );

    // Data pipeline: read data lands one cycle after enable, is registered, then clocked high a cycle later
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld       <= 1'b0;
            ld           <= 1'b0;
            bus.phy_clk  <= 1'b0;
            bus.phy_data <= '0;
        end else begin
            rd_vld       <= bus.lb_rd_ena;
            ld           <= rd_vld;
            bus.phy_clk  <= ld;
            if (rd_vld) bus.phy_data <= sel;
        end
    end

endmodule

// File: doc/hub75_line_shifter.md
Name: hub75_line_shifter

Overview:
- Read side of the HUB75 line buffer.
- Once armed for one bitplane, scans every column of the line buffer through its synchronous read port (1-cycle read latency).
- Extracts the selected plane bit of every bank/channel and drives the panel shift interface (data lines + shift clock).
- Sits between the line buffer and the panel PHY; the scan/BCM controller supplies go/plane and consumes done.

Parameters:
- N_BANKS, 2, rows shifted in parallel (upper/lower half of panel)
- N_CHANS, 3, colour channels per bank (R, G, B)
- N_PLANES, 8, bits per channel stored per column
- N_COLS, 64, columns per line; must be ≤ 2^ADDR_WIDTH
- ADDR_WIDTH, 6, line-buffer address width
- PLANE_WIDTH, 3, width of plane index; 2^PLANE_WIDTH ≥ N_PLANES

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- ctrl_go  in  1  start-line request; accepted only while ctrl_rdy=1
- ctrl_plane  in  PLANE_WIDTH  bitplane to shift; sampled with ctrl_go
- ctrl_rdy  out  1  idle and able to accept ctrl_go
- ctrl_done  out  1  one-cycle pulse at end of line
- lb_rd_addr  out  ADDR_WIDTH  line-buffer read address
- lb_rd_ena  out  1  line-buffer read enable
- lb_rd_data  in  N_BANKS*N_CHANS*N_PLANES  read data; valid the cycle after lb_rd_ena
- phy_data  out  N_BANKS*N_CHANS  panel data lines
- phy_clk  out  1  panel shift clock; panel samples on rising edge

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM→IDLE; ctrl_rdy=1; ctrl_done, lb_rd_ena, phy_clk=0; phy_data=0; lb_rd_addr=0.
- Reset mid-line aborts immediately: no done pulse; the partial line is discarded.
- Bit select: phy_data[b*N_CHANS+c] = lb_rd_data[(b*N_CHANS+c)*N_PLANES + plane].
- All outputs are registered.
- FSM states:
  - IDLE: ctrl_rdy=1. ctrl_go=1 latches plane, clears column counter, ctrl_rdy→0, next state SHIFT.
  - SHIFT: 2-cycle column period. Phase 0: lb_rd_ena=1, lb_rd_addr=col. Phase 1: lb_rd_ena=0, col++.
  - DRAIN: entered after the read of the last column; finishes the last data/clock pair.
  - DONE: one cycle; ctrl_done=1; next state IDLE.
- Timing, with ctrl_go sampled at edge 0:
  - Reads are issued in cycles 1, 3, 5, …, 2N_COLS-1.
  - phy_data for column k is valid from cycle 2k+3 with phy_clk=0.
  - phy_clk=1 in cycle 2k+4 with phy_data held.
  - After column N_COLS-1, phy_clk returns to 0 in cycle 2N_COLS+3, which is also the ctrl_done cycle.
  - ctrl_rdy=1 from cycle 2N_COLS+4.
  - Exactly N_COLS rising edges of phy_clk per line.
- phy_data holds its last value after the line ends.
- ctrl_go while ctrl_rdy=0: ignored, with no queuing.
- ctrl_go in the first IDLE cycle after done: accepted.
- ctrl_plane ≥ N_PLANES: undefined data; no hang, and the timing above still applies.
- Column counter is ADDR_WIDTH+1 bits wide, so N_COLS = 2^ADDR_WIDTH terminates correctly with no wrap.

Optional Feature:
- Macro: HUB75_LINE_SHIFTER_REVERSE_EN.
- When defined:
  - Adds input ctrl_rev (1 bit), sampled with ctrl_go.
  - If 1, columns are read N_COLS-1 down to 0 (for chained panels mounted upside-down); timing is identical.
- When undefined: port absent; ascending order only.

Decomposition:
- Shared package hub75_pkg holds:
  - FSM state encoding (IDLE/SHIFT/DRAIN/DONE).
  - Bit-index helper function: (bank, chan, plane) → word bit.
  - Default geometry constants.
- One natural sub-module: hub75_plane_select, a combinational N_BANKS*N_CHANS mux of one plane bit. The register stays in the parent.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0 for 3 cycles, release.
  - Required: ctrl_rdy=1, phy_clk=0, phy_data=0, lb_rd_ena=0, no done.
- Full line, plane 0 (defaults):
  - Stimulus: memory model with column k's plane-0 bits = k[5:0]; ctrl_go with plane=0.
  - Required: 64 phy_clk rises; at rise k, phy_data=k[5:0]; done at cycle 131; rdy at 132.
- Plane 7:
  - Stimulus: only plane-7 bits set, value 6'b101010 in all columns; plane=7.
  - Required: phy_data=6'b101010 at every rise; plane=3 yields 0.
- Go while busy and back-to-back:
  - Stimulus: ctrl_go held high continuously.
  - Required: second line starts the cycle after rdy rises; the go during shift is ignored; each line has exactly 64 clocks.
- Reset mid-line:
  - Stimulus: rst_n=0 at cycle 40.
  - Required: next cycle IDLE, no done pulse, lb_rd_ena=0; a new go yields a correct full line.
- Reverse (macro on):
  - Stimulus: ctrl_rev=1.
  - Required: lb_rd_addr sequence 63,62,…,0; first rise carries column 63 data; same done cycle.
